// File: rtl/din_sample_fifo.sv
// Circular sample FIFO between ADC capture and the demodulator datapath.
// Stores raw offset-binary words and emits signed, offset-corrected words on a registered read port.
module din_sample_fifo #(
  parameter int                        DIN_WORDLENGTH  = 16,
  parameter int                        DOUT_WORDLENGTH = 18,
  parameter int                        LOG2_DEPTH      = 4,
  parameter logic [DIN_WORDLENGTH-1:0] DIN_OFFSET      = DIN_WORDLENGTH'(32768)
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       DIN_IN_WEN,
  input  logic [DIN_WORDLENGTH-1:0]  DIN_IN_WDAT,
  output logic                       DIN_IN_FULL,
  input  logic                       DIN_OUT_REN,
  output logic [DOUT_WORDLENGTH-1:0] DIN_OUT_RDAT,
  output logic                       DIN_OUT_VALID,
  output logic                       DIN_OUT_EMPTY,
  output logic [LOG2_DEPTH:0]        DIN_COUNT,
  output logic                       DIN_OVERFLOW,
  output logic                       DIN_UNDERFLOW,
  input  logic                       DIN_CLR_ERR
);

  localparam int                  DEPTH     = 1 << LOG2_DEPTH;
  localparam int                  EXT_WIDTH = DOUT_WORDLENGTH - DIN_WORDLENGTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C   = {1'b1, {LOG2_DEPTH{1'b0}}};

  logic [DIN_WORDLENGTH-1:0]  mem_q [DEPTH];

  logic [LOG2_DEPTH-1:0]      wrPtr_q, wrPtr_d;
  logic [LOG2_DEPTH-1:0]      rdPtr_q, rdPtr_d;
  logic [LOG2_DEPTH:0]        count_q, count_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic [DOUT_WORDLENGTH-1:0] rdat_q, rdat_d;
  logic                       valid_q, valid_d;
  logic                       overflow_q, overflow_d;
  logic                       underflow_q, underflow_d;

  logic                       rdAcc;
  logic                       wrAcc;
  logic [DOUT_WORDLENGTH-1:0] rdWordExt;
  logic [DOUT_WORDLENGTH-1:0] offsetExt;

  // A write into a full FIFO is only taken when a read frees a slot in the same cycle.
  assign rdAcc = DIN_OUT_REN & ~empty_q;
  assign wrAcc = DIN_IN_WEN & (~full_q | rdAcc);

  assign rdWordExt = {{EXT_WIDTH{1'b0}}, mem_q[rdPtr_q]};
  assign offsetExt = {{EXT_WIDTH{1'b0}}, DIN_OFFSET};

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    rdat_d      = rdat_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wrAcc) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdAcc) begin
      rdPtr_d = rdPtr_q + 1'b1;
      rdat_d  = rdWordExt - offsetExt;
      valid_d = 1'b1;
    end

    case ({wrAcc, rdAcc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clearing loses to a fresh error event in the same cycle.
    if (DIN_CLR_ERR) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (DIN_IN_WEN & ~wrAcc) begin
      overflow_d = 1'b1;
    end
    if (DIN_OUT_REN & empty_q) begin
      underflow_d = 1'b1;
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rdat_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rdat_q      <= rdat_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not cleared by reset, but a write presented during reset is ignored.
  always_ff @(posedge CLK) begin
    if (RESET_N && wrAcc) begin
      mem_q[wrPtr_q] <= DIN_IN_WDAT;
    end
  end

  assign DIN_IN_FULL   = full_q;
  assign DIN_OUT_EMPTY = empty_q;
  assign DIN_COUNT     = count_q;
  assign DIN_OUT_RDAT  = rdat_q;
  assign DIN_OUT_VALID = valid_q;
  assign DIN_OVERFLOW  = overflow_q;
  assign DIN_UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_din_sample_fifo.sv
// Self-checking bench for din_sample_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_din_sample_fifo;

  localparam int DIN_W  = 16;
  localparam int DOUT_W = 18;
  localparam int LOG2D  = 4;
  localparam int DEPTH  = 1 << LOG2D;

  logic              clock;
  logic              resetN;
  logic              wen;
  logic [DIN_W-1:0]  wdat;
  logic              full;
  logic              ren;
  logic [DOUT_W-1:0] rdat;
  logic              valid;
  logic              empty;
  logic [LOG2D:0]    count;
  logic              overflow;
  logic              underflow;
  logic              clrErr;

  din_sample_fifo #(
    .DIN_WORDLENGTH (DIN_W),
    .DOUT_WORDLENGTH(DOUT_W),
    .LOG2_DEPTH     (LOG2D),
    .DIN_OFFSET     (16'd32768)
  ) dut (
    .CLK          (clock),
    .RESET_N      (resetN),
    .DIN_IN_WEN   (wen),
    .DIN_IN_WDAT  (wdat),
    .DIN_IN_FULL  (full),
    .DIN_OUT_REN  (ren),
    .DIN_OUT_RDAT (rdat),
    .DIN_OUT_VALID(valid),
    .DIN_OUT_EMPTY(empty),
    .DIN_COUNT    (count),
    .DIN_OVERFLOW (overflow),
    .DIN_UNDERFLOW(underflow),
    .DIN_CLR_ERR  (clrErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of stored words plus expected output registers.
  int unsigned       modelQ[$];
  logic [DOUT_W-1:0] expRdat;
  logic              expValid;
  logic              expOvf;
  logic              expUdf;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " count"}, 32'(count), 32'(modelQ.size()));
    checkOutput({tag, " empty"}, 32'(empty), 32'(modelQ.size() == 0));
    checkOutput({tag, " full"}, 32'(full), 32'(modelQ.size() == DEPTH));
    checkOutput({tag, " valid"}, 32'(valid), 32'(expValid));
    checkOutput({tag, " rdat"}, 32'(rdat), 32'(expRdat));
    checkOutput({tag, " ovf"}, 32'(overflow), 32'(expOvf));
    checkOutput({tag, " udf"}, 32'(underflow), 32'(expUdf));
  endtask

  // One clock cycle of traffic: model predicts from the pre-edge occupancy, then outputs are compared.
  task automatic applyStimulus(input logic w, input logic [DIN_W-1:0] d, input logic r,
                               input logic clr, input string tag);
    bit canRead;
    bit canWrite;
    int unsigned word;
    wen    = w;
    wdat   = d;
    ren    = r;
    clrErr = clr;
    canRead  = r && (modelQ.size() > 0);
    canWrite = w && ((modelQ.size() < DEPTH) || canRead);
    if (clr) begin
      expOvf = 1'b0;
      expUdf = 1'b0;
    end
    if (w && !canWrite) expOvf = 1'b1;
    if (r && modelQ.size() == 0) expUdf = 1'b1;
    expValid = canRead;
    if (canRead) begin
      word    = modelQ.pop_front();
      expRdat = DOUT_W'(word) - DOUT_W'(32768);
    end
    if (canWrite) modelQ.push_back(int'(d));
    @(posedge clock);
    #1;
    checkAll(tag);
  endtask

  task automatic applyReset(input logic r, input logic w);
    resetN = 1'b0;
    wen    = w;
    wdat   = DIN_W'($urandom);
    ren    = r;
    clrErr = 1'b0;
    @(posedge clock);
    #1;
    resetN = 1'b1;
    modelQ.delete();
    expRdat  = '0;
    expValid = 1'b0;
    expOvf   = 1'b0;
    expUdf   = 1'b0;
    checkAll("reset");
  endtask

  initial begin
    resetN = 1'b1;
    wen    = 1'b0;
    wdat   = '0;
    ren    = 1'b0;
    clrErr = 1'b0;
    expRdat = '0; expValid = 1'b0; expOvf = 1'b0; expUdf = 1'b0;
    @(posedge clock);
    #1;
    applyReset(1'b0, 1'b0);

    // Offset-binary conversion of midscale, zero and full scale.
    applyStimulus(1, 16'h8000, 0, 0, "t1 wr");
    applyStimulus(1, 16'h0000, 0, 0, "t1 wr");
    applyStimulus(1, 16'hFFFF, 0, 0, "t1 wr");
    applyStimulus(0, 16'h0, 1, 0, "t1 rd");
    checkOutput("t1 midscale", 32'(rdat), 32'h00000);
    applyStimulus(0, 16'h0, 1, 0, "t1 rd");
    checkOutput("t1 negfull", 32'(rdat), 32'h38000);
    applyStimulus(0, 16'h0, 1, 0, "t1 rd");
    checkOutput("t1 posfull", 32'(rdat), 32'h07FFF);
    applyStimulus(0, 16'h0, 0, 0, "t1 idle");
    checkOutput("t1 rdat hold", 32'(rdat), 32'h07FFF);

    // Fill to full, overflow, clear.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, DIN_W'(i), 0, 0, "t2 fill");
    checkOutput("t2 full", 32'(full), 32'd1);
    checkOutput("t2 count16", 32'(count), 32'd16);
    applyStimulus(1, 16'hABCD, 0, 0, "t2 drop");
    checkOutput("t2 ovf set", 32'(overflow), 32'd1);
    applyStimulus(0, 16'h0, 0, 1, "t2 clr");
    checkOutput("t2 ovf clr", 32'(overflow), 32'd0);

    // Simultaneous read and write while full; pointers wrap.
    for (int i = 0; i < 20; i++) applyStimulus(1, DIN_W'(16'h9000 + i), 1, 0, "t3 rw");
    checkOutput("t3 count", 32'(count), 32'd16);

    // Drain, then read+write on empty.
    while (modelQ.size() > 0) applyStimulus(0, 16'h0, 1, 0, "t4 drain");
    applyStimulus(1, 16'h8005, 1, 0, "t4 rw empty");
    checkOutput("t4 udf", 32'(underflow), 32'd1);
    checkOutput("t4 nvalid", 32'(valid), 32'd0);
    applyStimulus(0, 16'h0, 1, 0, "t4 rd");
    checkOutput("t4 rdat5", 32'(rdat), 32'h00005);

    // Reset with data stored and a read pending.
    for (int i = 0; i < 4; i++) applyStimulus(1, DIN_W'(16'h1234 + i), 0, 0, "t5 wr");
    applyReset(1'b1, 1'b1);
    applyStimulus(1, 16'h8100, 0, 0, "t5 wr new");
    applyStimulus(0, 16'h0, 1, 0, "t5 rd new");
    checkOutput("t5 rdat", 32'(rdat), 32'h00100);

    // Clear concurrent with an underflow event: set wins.
    applyStimulus(0, 16'h0, 1, 1, "t6 clr+udf");
    checkOutput("t6 udf stays", 32'(underflow), 32'd1);
    applyStimulus(0, 16'h0, 0, 1, "t6 clr");

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset(1'($urandom), 1'($urandom));
      end else begin
        applyStimulus(1'($urandom_range(0, 99) < ((i / 100) % 2 ? 35 : 65)),
                      DIN_W'($urandom),
                      1'($urandom_range(0, 99) < ((i / 100) % 2 ? 65 : 35)),
                      1'($urandom_range(0, 19) == 0),
                      "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
